csr_timer: RTL and testbench

- Timer/counter CSR bank on the same CSR access bus as the main CSR register file.
- Implements TID (0x40), TCFG (0x41), TVAL (0x42) and TICLR (0x44), plus a 64-bit stable counter for rdcntvl.w/rdcntvh.w/rdcntid.
- Produces the level timer interrupt that drives ESTAT.IS[11] in the CSR register file.
- The top level merges read data using csr_hit.

---
 rtl/csr_timer_pkg.sv | 16 +
 rtl/csr_timer_stable_counter.sv | 12 +
 rtl/csr_timer.sv | 57 +++++
 tb/tb_csr_timer.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/csr_timer_pkg.sv
// csr_timer_pkg: CSR addresses, TCFG/TICLR field positions and masked-write helper for the timer bank.
package csr_timer_pkg;
  localparam logic [13:0] CSR_TID   = 14'h40;
  localparam logic [13:0] CSR_TCFG  = 14'h41;
  localparam logic [13:0] CSR_TVAL  = 14'h42;
  localparam logic [13:0] CSR_TICLR = 14'h44;
  localparam int CSR_TCFG_EN       = 0;
  localparam int CSR_TCFG_PERIOD   = 1;
  localparam int CSR_TCFG_INITV_HI = 31;
  localparam int CSR_TCFG_INITV_LO = 2;
  localparam int CSR_TICLR_CLR     = 0;
  localparam logic [31:0] TVAL_IDLE = 32'hFFFF_FFFF;
  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wmask, input logic [31:0] wvalue);
    return (wmask & wvalue) | (~wmask & old);
  endfunction
endpackage

// File: rtl/csr_timer_stable_counter.sv
// csr_timer_stable_counter: free-running CNT_W-bit counter behind rdcntvl.w/rdcntvh.w.
module csr_timer_stable_counter #(
  parameter int CNT_W = 64
) (
  input  logic             clk,
  input  logic             resetn,
  output logic [CNT_W-1:0] cnt
);
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) cnt <= '0;
    else cnt <= cnt + CNT_W'(1);
endmodule

// File: rtl/csr_timer.sv
// csr_timer: TID/TCFG/TVAL/TICLR timer CSRs, level timer interrupt and stable counter.
module csr_timer
  import csr_timer_pkg::*;
#(
  parameter logic [31:0] CORE_ID = 32'h0,
  parameter int          CNT_W   = 64
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             csr_re,
  input  logic [13:0]      csr_num,
  input  logic             csr_we,
  input  logic [31:0]      csr_wmask,
  input  logic [31:0]      csr_wvalue,
  output logic             csr_hit,
  output logic [31:0]      csr_rvalue,
  output logic             timer_int,
  output logic [31:0]      counter_id,
  output logic [CNT_W-1:0] stable_cnt
);
  logic [31:0] tid, tcfg, tval, tcfg_new, tval_load, tval_init;
  logic        ti, tid_we, tcfg_we, ticlr_we, en, expire, unused_re;
  assign unused_re = csr_re;
  assign tid_we    = csr_we && csr_num == CSR_TID;
  assign tcfg_we   = csr_we && csr_num == CSR_TCFG;
  assign ticlr_we  = csr_we && csr_num == CSR_TICLR;
  assign tcfg_new  = merge(tcfg, csr_wmask, csr_wvalue);
  assign tval_load = {tcfg_new[CSR_TCFG_INITV_HI:CSR_TCFG_INITV_LO], 2'b00};
  assign tval_init = {tcfg[CSR_TCFG_INITV_HI:CSR_TCFG_INITV_LO], 2'b00};
  assign en        = tcfg[CSR_TCFG_EN];
  assign expire    = en && tval == 32'd0;
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      tid  <= CORE_ID;
      tcfg <= '0;
      tval <= TVAL_IDLE;
      ti   <= 1'b0;
    end else begin
      if (tid_we) tid <= merge(tid, csr_wmask, csr_wvalue);
      if (tcfg_we) tcfg <= tcfg_new;
      // a fresh enable load beats decrement/reload; an idle one-shot stays frozen at TVAL_IDLE
      if (tcfg_we && tcfg_new[CSR_TCFG_EN]) tval <= tval_load;
      else if (en && tval != TVAL_IDLE)
        tval <= (tval == 32'd0 && tcfg[CSR_TCFG_PERIOD]) ? tval_init : tval - 32'd1;
      if (expire) ti <= 1'b1;
      else if (ticlr_we && csr_wmask[CSR_TICLR_CLR] && csr_wvalue[CSR_TICLR_CLR]) ti <= 1'b0;
    end
  always_comb begin
    csr_hit    = csr_num == CSR_TID || csr_num == CSR_TCFG || csr_num == CSR_TVAL || csr_num == CSR_TICLR;
    csr_rvalue = csr_num == CSR_TID  ? tid  :
                 csr_num == CSR_TCFG ? tcfg :
                 csr_num == CSR_TVAL ? tval : 32'd0;
  end
  assign timer_int  = ti;
  assign counter_id = tid;
  csr_timer_stable_counter #(.CNT_W(CNT_W)) u_cnt (.clk(clk), .resetn(resetn), .cnt(stable_cnt));
endmodule

// File: tb/tb_csr_timer.sv
// tb_csr_timer: directed plan scenarios plus random CSR traffic against a spec-level timer model.
module tb_csr_timer;
  localparam logic [31:0] CORE_ID = 32'h0000_0005;
  logic        clk = 1'b0, resetn = 1'b0, csr_re = 1'b1, csr_we = 1'b0, csr_hit, timer_int;
  logic [13:0] csr_num = 14'h0;
  logic [31:0] csr_wmask = '0, csr_wvalue = '0, csr_rvalue, counter_id;
  logic [63:0] stable_cnt;
  int n_chk = 0, n_pass = 0;
  longint m_tid, m_tval, m_cnt;
  int     m_en, m_per, m_initv, m_ti;
  csr_timer #(.CORE_ID(CORE_ID), .CNT_W(64)) dut (
    .clk(clk), .resetn(resetn), .csr_re(csr_re), .csr_num(csr_num), .csr_we(csr_we),
    .csr_wmask(csr_wmask), .csr_wvalue(csr_wvalue), .csr_hit(csr_hit), .csr_rvalue(csr_rvalue),
    .timer_int(timer_int), .counter_id(counter_id), .stable_cnt(stable_cnt));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  function automatic longint m_tcfg();
    return (longint'(m_initv) << 2) | (longint'(m_per) << 1) | longint'(m_en);
  endfunction
  function automatic longint m_read(input int num);
    return num == 'h40 ? m_tid : num == 'h41 ? m_tcfg() : num == 'h42 ? m_tval : 0;
  endfunction
  task automatic m_reset();
    m_tid = CORE_ID; m_en = 0; m_per = 0; m_initv = 0; m_tval = 64'hFFFF_FFFF; m_ti = 0; m_cnt = 0;
  endtask
  // one clock: drive at negedge, check reads, advance the model at the edge, check registered outputs
  task automatic step(input logic we, input int num, input logic [31:0] mask, input logic [31:0] val);
    longint old_cfg, new_cfg;
    int fire;
    csr_we = we; csr_num = 14'(num); csr_wmask = mask; csr_wvalue = val;
    #1;
    chk("hit", csr_hit, (num == 'h40 || num == 'h41 || num == 'h42 || num == 'h44) ? 1 : 0);
    chk("rvalue", csr_rvalue, m_read(num));
    @(posedge clk);
    fire = (m_en == 1 && m_tval == 0) ? 1 : 0;
    if (m_en == 1 && m_tval != 64'hFFFF_FFFF)
      m_tval = (m_tval == 0 && m_per == 1) ? longint'(m_initv) * 4 : (m_tval + 64'hFFFF_FFFF) % 64'h1_0000_0000;
    if (we && num == 'h40) m_tid = (mask & val) | (~mask & m_tid[31:0]);
    if (we && num == 'h41) begin
      old_cfg = m_tcfg();
      new_cfg = (mask & val) | (~mask & old_cfg[31:0]);
      m_en = int'(new_cfg[0]); m_per = int'(new_cfg[1]); m_initv = int'(new_cfg[31:2]);
      if (m_en == 1) m_tval = longint'(m_initv) * 4;
    end
    if (fire == 1) m_ti = 1;
    else if (we && num == 'h44 && mask[0] && val[0]) m_ti = 0;
    m_cnt++;
    @(negedge clk);
    chk("timer_int", timer_int, m_ti);
    chk("counter_id", counter_id, m_tid);
    chk("stable_cnt", stable_cnt, m_cnt);
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 'h42, '0, '0);
  endtask
  task automatic wait_tval(input longint v, input int ti_req);
    int k = 0;
    while (!(m_tval == v && (ti_req < 0 || m_ti == ti_req)) && k < 200) begin
      step(1'b0, 'h42, '0, '0);
      k++;
    end
    if (k >= 200) chk("wait_timeout", 0, 1);
  endtask
  initial begin
    int num, sel;
    logic [31:0] tv;
    m_reset();
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("rst_timer_int", timer_int, 0);
    chk("rst_tid", counter_id, CORE_ID);
    chk("rst_cnt", stable_cnt, 0);
    csr_num = 14'h41; #1 chk("rst_tcfg", csr_rvalue, 0);
    csr_num = 14'h42; #1 chk("rst_tval", csr_rvalue, 32'hFFFF_FFFF);
    @(negedge clk);
    resetn = 1'b1;
    idle(3);
    chk("cnt_counts", stable_cnt, 3);
    // one-shot N=16
    step(1'b1, 'h41, 32'hFFFF_FFFF, 32'h11);
    csr_num = 14'h42; #1 chk("os_load", csr_rvalue, 16);
    idle(15);
    chk("os_not_yet", timer_int, 0);
    idle(1);
    #1 chk("os_zero", csr_rvalue, 0);
    idle(1);
    chk("os_fire", timer_int, 1);
    #1 chk("os_idle", csr_rvalue, 32'hFFFF_FFFF);
    step(1'b1, 'h44, 32'h1, 32'h1);
    chk("os_clr", timer_int, 0);
    idle(20);
    chk("os_no_refire", timer_int, 0);
    // periodic N=8, clear between expiries
    step(1'b1, 'h41, 32'hFFFF_FFFF, 32'hB);
    idle(30);
    step(1'b1, 'h44, 32'hFFFF_FFFF, 32'h1);
    idle(12);
    // TICLR colliding with expiry
    wait_tval(0, -1);
    step(1'b1, 'h44, 32'hFFFF_FFFF, 32'h1);
    chk("collide_set_wins", timer_int, 1);
    // masked disable freezes TVAL
    step(1'b1, 'h41, 32'hFFFF_FFFF, 32'h21);
    idle(3);
    step(1'b1, 'h41, 32'h1, 32'h0);
    csr_num = 14'h42; #1 tv = csr_rvalue;
    idle(4);
    #1 chk("frozen_tval", csr_rvalue, tv);
    csr_num = 14'h41; #1 chk("mask_initv", csr_rvalue, 32'h20);
    step(1'b1, 'h42, 32'hFFFF_FFFF, 32'h1234);
    step(1'b1, 'h44, 32'hFFFF_FFFF, 32'h0);
    step(1'b1, 'h40, 32'h0000_FFFF, 32'hABCD_1234);
    // async reset mid-count with TVAL=5, TI=1
    step(1'b1, 'h41, 32'hFFFF_FFFF, 32'hB);
    wait_tval(5, 1);
    #2 resetn = 1'b0;
    #1;
    m_reset();
    chk("arst_timer_int", timer_int, 0);
    chk("arst_tid", counter_id, CORE_ID);
    chk("arst_cnt", stable_cnt, 0);
    csr_num = 14'h42; #1 chk("arst_tval", csr_rvalue, 32'hFFFF_FFFF);
    @(negedge clk);
    resetn = 1'b1;
    idle(10);
    chk("arst_no_int", timer_int, 0);
    // random traffic
    for (int i = 0; i < 800; i++) begin
      sel = $urandom_range(0, 9);
      num = sel < 2 ? 'h41 : sel < 3 ? 'h44 : sel < 4 ? 'h40 : sel < 6 ? 'h42 : sel < 7 ? 'h43 : $urandom_range(0, 'h7F);
      step(1'($urandom_range(0, 3) == 0), num,
           $urandom_range(0, 3) == 0 ? $urandom : 32'hFFFF_FFFF,
           num == 'h41 ? 32'($urandom_range(0, 31)) : $urandom);
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
